alg_initiator: RTL

Initiator / requester side of the level start/done handshake used by the team's multi-step algorithm blocks (BITWIDTH-parameterised, operands a/b, result y). Accepts operand pairs over a valid/ready stream and buffers them in an internal FIFO. Issues one job at a time to the attached algorithm responder and returns each result over a valid/ready output stream. It sits between the pipeline/valid-stream front end and any start/done compute engine.

---
 rtl/alg_initiator_pkg.sv | 13 +
 rtl/alg_initiator_if.sv | 37 +++
 rtl/alg_op_fifo.sv | 63 ++++++
 rtl/alg_initiator.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alg_initiator_pkg.sv
// Shared definitions for the algorithm initiator: handshake FSM states and default data width.
package alg_initiator_pkg;

  // Operand/result MSB index used when a block does not override BITWIDTH.
  localparam int unsigned DEFAULT_BITWIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } alg_state_e;

endpackage

// File: rtl/alg_initiator_if.sv
// Bundles the three streams around the initiator: operand input, responder start/done job
// channel and result output. Signal suffixes are relative to the initiator (master).
interface alg_initiator_if
  import alg_initiator_pkg::*;
#(
  parameter int unsigned BITWIDTH = DEFAULT_BITWIDTH
);

  // Operand stream in
  logic                in_valid_i;
  logic                in_ready_o;
  logic [BITWIDTH:0]   in_a_i;
  logic [BITWIDTH:0]   in_b_i;

  // Job channel to the responder
  logic                start_o;
  logic [BITWIDTH:0]   a_o;
  logic [BITWIDTH:0]   b_o;
  logic                done_i;
  logic [BITWIDTH:0]   y_i;

  // Result stream out
  logic                out_valid_o;
  logic                out_ready_i;
  logic [BITWIDTH:0]   out_y_o;

  modport master (
    input  in_valid_i, in_a_i, in_b_i, done_i, y_i, out_ready_i,
    output in_ready_o, start_o, a_o, b_o, out_valid_o, out_y_o
  );

  modport slave (
    output in_valid_i, in_a_i, in_b_i, done_i, y_i, out_ready_i,
    input  in_ready_o, start_o, a_o, b_o, out_valid_o, out_y_o
  );

endinterface

// File: rtl/alg_op_fifo.sv
// Synchronous operand FIFO with full/empty flags. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter.
module alg_op_fifo
  import alg_initiator_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * (DEFAULT_BITWIDTH + 1),
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, empty;
  logic             push_en, pop_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  // A push into a full FIFO is refused even if a pop happens in the same cycle.
  assign push_en = push_i & ~full;
  assign pop_en  = pop_i & ~empty;

  assign full_o  = full;
  assign empty_o = empty;
  assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  // Next pointer values; the power-of-two depth makes wrap-around implicit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (push_en) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/alg_initiator.sv
// Requester side of the level start/done handshake. Operand pairs are queued in alg_op_fifo,
// issued one job at a time to the responder, and results are returned on a valid/ready stream.
// Optional macro ALG_TIMEOUT_EN adds a REQ watchdog that abandons a job and sets a sticky err_o.
module alg_initiator
  import alg_initiator_pkg::*;
#(
  parameter int unsigned BITWIDTH       = DEFAULT_BITWIDTH,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            CLK,
  input  logic            RST,
  alg_initiator_if.master bus,
  output logic            busy_o,
  output logic            err_o
);

  localparam int unsigned DataW = BITWIDTH + 1;

  logic [2*DataW-1:0] fifo_wdata, fifo_rdata;
  logic               fifo_full, fifo_empty, fifo_pop;

  alg_state_e         state_q, state_d;
  logic [DataW-1:0]   a_q, a_d, b_q, b_d;
  logic               start_q, start_d;
  logic               out_valid_q, out_valid_d;
  logic [DataW-1:0]   out_y_q, out_y_d;
  logic               slot_free;

`ifdef ALG_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            err_q, err_d;
  assign cnt_inc = cnt_q + 1'b1;
`endif

  assign fifo_wdata = {bus.in_a_i, bus.in_b_i};

  alg_op_fifo #(
    .WIDTH (2 * DataW),
    .DEPTH (FIFO_DEPTH)
  ) u_op_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (bus.in_valid_i),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Output slot is usable if empty or being drained this very cycle.
  assign slot_free = ~out_valid_q | bus.out_ready_i;

  // Handshake FSM next state, operand/result registers and FIFO pop.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    start_d     = start_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    fifo_pop    = 1'b0;
`ifdef ALG_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif

    if (out_valid_q && bus.out_ready_i) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A done still high from an earlier job must clear before a new start.
        if (!fifo_empty && slot_free && !bus.done_i) begin
          state_d  = ST_REQ;
          fifo_pop = 1'b1;
          a_d      = fifo_rdata[2*DataW-1:DataW];
          b_d      = fifo_rdata[DataW-1:0];
          start_d  = 1'b1;
`ifdef ALG_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ST_REQ: begin
`ifdef ALG_TIMEOUT_EN
        cnt_d = cnt_inc;
`endif
        if (bus.done_i) begin
          out_y_d     = bus.y_i;
          out_valid_d = 1'b1;
          start_d     = 1'b0;
          state_d     = ST_REL;
`ifdef ALG_TIMEOUT_EN
        end else if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
          // Abandon the job: no result is produced for it.
          start_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_REL;
`endif
        end
      end
      ST_REL: begin
        if (!bus.done_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
    end
  end

`ifdef ALG_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign err_o = 1'b0;
`endif

  assign bus.in_ready_o  = ~fifo_full;
  assign bus.start_o     = start_q;
  assign bus.a_o         = a_q;
  assign bus.b_o         = b_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_y_o     = out_y_q;
  assign busy_o          = (state_q != ST_IDLE) | ~fifo_empty;

endmodule
